matmul_job_scheduler: RTL and testbench
=======================================

// Module: matmul_job_scheduler
// PURPOSE
//  Round-robin scheduler sharing one HLS matrix_mult kernel (ap_ctrl_chain) among NUM_REQ requesters.
//  Grants one job at a time, drives kernel ap_start/ap_continue, steers the kernel memory-port mux via sel.
//  Measures per-job latency, counts completed jobs, and enforces a run-time watchdog.
//  Sits between the requester fabric and the matrix_mult instance.
// PARAMETERS
//  NUM_REQ   4      number of requesters (2..16)
//  REQ_W     $clog2(NUM_REQ)  width of sel
//  CNT_W     32     width of latency/job counters
//  TIMEOUT   4096   max cycles from start to ap_done before fault
// PORTS
//  ap_clk            in   1        clock
//  ap_rst_n          in   1        reset, asynchronous, active-low
//  req_valid         in   NUM_REQ  per-requester job request, level, held until req_ready
//  req_ready         out  NUM_REQ  one-cycle grant pulse, one-hot
//  req_done          out  NUM_REQ  one-cycle completion pulse to granted requester
//  req_err           out  NUM_REQ  one-cycle timeout pulse to granted requester
//  sel               out  REQ_W    index of owning requester; stable while busy
//  busy              out  1        high from grant until return to IDLE
//  kern_ap_start     out  1        kernel start
//  kern_ap_ready     in   1        kernel accepted inputs
//  kern_ap_done      in   1        kernel finished
//  kern_ap_idle      in   1        kernel idle
//  kern_ap_continue  out  1        kernel output acknowledge
//  last_latency      out  CNT_W    cycles of last successful job
//  job_count         out  CNT_W    successful jobs, saturating
// BEHAVIOUR
//  Reset (async, ap_rst_n=0): state=IDLE; all outputs 0; rr pointer=0; counters 0.
//  FSM states: IDLE, START, RUN, DONE, DRAIN.
//  IDLE: if any req_valid and kern_ap_idle=1: pick first valid index at or after rr pointer (wrap mod NUM_REQ);
//    register sel=idx, pulse req_ready[idx] same cycle as transition, busy<=1, lat_cnt<=1, go START.
//    No request or kernel not idle: stay, nothing granted.
//  START: kern_ap_start=1 held every cycle until kern_ap_ready sampled 1; then start deasserts next cycle.
//    ready=1 and done=0 -> RUN; ready=1 and done=1 same cycle -> DONE.
//  RUN: kern_ap_start=0; wait kern_ap_done=1 -> DONE.
//  lat_cnt increments every cycle in START and RUN; counts first start cycle through done cycle inclusive.
//  Watchdog: in START or RUN, lat_cnt==TIMEOUT with no done -> DRAIN; req_err[sel] pulses on that transition.
//  DONE (1 cycle): kern_ap_continue=1; req_done[sel]=1; last_latency<=lat_cnt; job_count<=job_count+1
//    unless all-ones (saturate); rr pointer<=(sel+1) mod NUM_REQ; -> IDLE; busy<=0.
//  DRAIN: kern_ap_start=0, kern_ap_continue=1 held; wait kern_ap_idle=1 -> IDLE;
//    rr pointer<=(sel+1) mod NUM_REQ; last_latency and job_count unchanged.
//  Requester that drops req_valid before grant is simply skipped; after grant req_valid is ignored until IDLE.
//  At most one req_ready/req_done/req_err bit high in any cycle; req_done and req_err never for the same job.
//  kern_ap_done outside START/RUN is ignored.
//  Reset mid-job: all state cleared immediately; no req_done/req_err emitted for the aborted job.
// TESTING
//  1. Single req_valid[2]=1, kernel ready after 1 cyc, done 20 cyc later -> req_ready[2] once, sel=2, req_done[2] once,
//     last_latency=21, job_count=1.
//  2. req_valid=4'b1111 held, 8 jobs -> grant order 0,1,2,3,0,1,2,3; no back-to-back grant to same index.
//  3. Kernel holds ap_ready=0 for 5 cycles -> kern_ap_start stays 1 all 6 cycles, drops the cycle after ready.
//  4. Kernel never asserts done, TIMEOUT=64 -> req_err[sel] pulses at lat_cnt=64, state waits in DRAIN until
//     kern_ap_idle=1; job_count unchanged; next requester granted afterwards.
//  5. ap_ready and ap_done in same cycle -> DONE next cycle, last_latency=1, exactly one req_done.
//  6. ap_rst_n low during RUN -> all outputs 0 asynchronously, no done/err pulse; after release, pending req re-granted from index 0.

Source files
------------

// File: rtl/matmul_job_scheduler.sv
// matmul_job_scheduler
//   Round-robin scheduler that shares one matrix_mult kernel (ap_ctrl_chain)
//   among NUM_REQ requesters. It grants one job at a time and drives the kernel
//   ap_start/ap_continue handshake. It steers the kernel memory-port mux
//   through sel, measures per-job latency, counts completed jobs and aborts a
//   job that runs too long.
//
//   Ports
//     ap_clk, ap_rst_n     clock, asynchronous active-low reset
//     req_valid[N]         level request per requester, held until req_ready
//     req_ready[N]         one-cycle one-hot grant pulse
//     req_done[N]          one-cycle completion pulse to the owning requester
//     req_err[N]           one-cycle watchdog pulse to the owning requester
//     sel                  index of the owning requester, stable while busy
//     busy                 high from grant until the scheduler is idle again
//     kern_ap_*            ap_ctrl_chain handshake with the kernel
//     last_latency         cycles (first start .. done inclusive) of last good job
//     job_count            number of successful jobs, saturating
module matmul_job_scheduler #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic               ap_clk,
   input  logic               ap_rst_n,
   input  logic [NUM_REQ-1:0] req_valid,
   output logic [NUM_REQ-1:0] req_ready,
   output logic [NUM_REQ-1:0] req_done,
   output logic [NUM_REQ-1:0] req_err,
   output logic [REQ_W-1:0]   sel,
   output logic               busy,
   output logic               kern_ap_start,
   input  logic               kern_ap_ready,
   input  logic               kern_ap_done,
   input  logic               kern_ap_idle,
   output logic               kern_ap_continue,
   output logic [CNT_W-1:0]   last_latency,
   output logic [CNT_W-1:0]   job_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_RUN   = 3'd2,
      S_DONE  = 3'd3,
      S_DRAIN = 3'd4
   } state_e;

   state_e               state_q, state_d;
   logic [REQ_W-1:0]     sel_q, sel_d;
   logic [REQ_W-1:0]     rr_q, rr_d;
   logic [CNT_W-1:0]     lat_q, lat_d;
   logic [CNT_W-1:0]     last_lat_q, last_lat_d;
   logic [CNT_W-1:0]     job_cnt_q, job_cnt_d;
   logic [NUM_REQ-1:0]   ready_q, ready_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic [NUM_REQ-1:0]   err_q, err_d;
   logic                 busy_q, busy_d;
   logic                 start_q, start_d;
   logic                 cont_q, cont_d;

   logic [NUM_REQ-1:0]   hi_req_s;
   logic [REQ_W-1:0]     hi_idx_s;
   logic [REQ_W-1:0]     low_idx_s;
   logic [REQ_W-1:0]     grant_idx_s;
   logic                 timeout_s;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [REQ_W-1:0] idx);
      onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
   endfunction

   function automatic logic [REQ_W-1:0] wrap_inc(input logic [REQ_W-1:0] idx);
      wrap_inc = (idx == REQ_W'(NUM_REQ - 1)) ? {REQ_W{1'b0}} : idx + {{(REQ_W-1){1'b0}}, 1'b1};
   endfunction

   assign timeout_s = (lat_q == CNT_W'(TIMEOUT));

   // Round-robin pick: lowest valid index at or above rr_q, else lowest valid overall (wrap).
   always_comb begin
      hi_req_s  = {NUM_REQ{1'b0}};
      hi_idx_s  = {REQ_W{1'b0}};
      low_idx_s = {REQ_W{1'b0}};
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         hi_req_s[i] = (i >= int'(rr_q)) ? req_valid[i] : 1'b0;
      end
      // Descending scan so the lowest matching index is the one left standing.
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         low_idx_s = req_valid[i] ? REQ_W'(i) : low_idx_s;
         hi_idx_s  = hi_req_s[i]  ? REQ_W'(i) : hi_idx_s;
      end
      grant_idx_s = (|hi_req_s) ? hi_idx_s : low_idx_s;
   end

   // Next-state and next-output logic of the job FSM.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      rr_d       = rr_q;
      lat_d      = lat_q;
      last_lat_d = last_lat_q;
      job_cnt_d  = job_cnt_q;
      ready_d    = {NUM_REQ{1'b0}};
      done_d     = {NUM_REQ{1'b0}};
      err_d      = {NUM_REQ{1'b0}};
      case (state_q)
         S_IDLE: begin
            if ((|req_valid) && kern_ap_idle) begin
               state_d = S_START;
               sel_d   = grant_idx_s;
               ready_d = onehot(grant_idx_s);
               lat_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            // done is only meaningful once the kernel has accepted the start.
            if (kern_ap_ready && kern_ap_done) begin
               state_d = S_DONE;
               done_d  = onehot(sel_q);
            end else if (timeout_s) begin
               state_d = S_DRAIN;
               err_d   = onehot(sel_q);
            end else if (kern_ap_ready) begin
               state_d = S_RUN;
               lat_d   = lat_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               lat_d   = lat_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         S_RUN: begin
            if (kern_ap_done) begin
               state_d = S_DONE;
               done_d  = onehot(sel_q);
            end else if (timeout_s) begin
               state_d = S_DRAIN;
               err_d   = onehot(sel_q);
            end else begin
               lat_d   = lat_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         S_DONE: begin
            state_d    = S_IDLE;
            last_lat_d = lat_q;
            job_cnt_d  = (job_cnt_q == {CNT_W{1'b1}}) ? job_cnt_q
                                                       : job_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            rr_d       = wrap_inc(sel_q);
         end
         S_DRAIN: begin
            if (kern_ap_idle) begin
               state_d = S_IDLE;
               rr_d    = wrap_inc(sel_q);
            end else begin
               state_d = S_DRAIN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d  = (state_d != S_IDLE);
      start_d = (state_d == S_START);
      cont_d  = (state_d == S_DONE) || (state_d == S_DRAIN);
   end

   // State and registered-output flops; reset clears everything, aborting any job silently.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q    <= S_IDLE;
         sel_q      <= {REQ_W{1'b0}};
         rr_q       <= {REQ_W{1'b0}};
         lat_q      <= {CNT_W{1'b0}};
         last_lat_q <= {CNT_W{1'b0}};
         job_cnt_q  <= {CNT_W{1'b0}};
         ready_q    <= {NUM_REQ{1'b0}};
         done_q     <= {NUM_REQ{1'b0}};
         err_q      <= {NUM_REQ{1'b0}};
         busy_q     <= 1'b0;
         start_q    <= 1'b0;
         cont_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         rr_q       <= rr_d;
         lat_q      <= lat_d;
         last_lat_q <= last_lat_d;
         job_cnt_q  <= job_cnt_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         start_q    <= start_d;
         cont_q     <= cont_d;
      end
   end

   assign req_ready        = ready_q;
   assign req_done         = done_q;
   assign req_err          = err_q;
   assign sel              = sel_q;
   assign busy             = busy_q;
   assign kern_ap_start    = start_q;
   assign kern_ap_continue = cont_q;
   assign last_latency     = last_lat_q;
   assign job_count        = job_cnt_q;

endmodule

// File: tb/tb_matmul_job_scheduler.sv
module tb_matmul_job_scheduler;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [3:0]  req_done;
   logic [3:0]  req_err;
   logic [1:0]  sel;
   logic        busy;
   logic        kern_ap_start;
   logic        kern_ap_ready;
   logic        kern_ap_done;
   logic        kern_ap_idle;
   logic        kern_ap_continue;
   logic [31:0] last_latency;
   logic [31:0] job_count;

   int checks   = 0;
   int failures = 0;
   int exp_jobs = 0;
   int exp_last = 0;

   matmul_job_scheduler #(
      .NUM_REQ (4),
      .CNT_W   (32),
      .TIMEOUT (64)
   ) dut (
      .ap_clk           (ap_clk),
      .ap_rst_n         (ap_rst_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_done         (req_done),
      .req_err          (req_err),
      .sel              (sel),
      .busy             (busy),
      .kern_ap_start    (kern_ap_start),
      .kern_ap_ready    (kern_ap_ready),
      .kern_ap_done     (kern_ap_done),
      .kern_ap_idle     (kern_ap_idle),
      .kern_ap_continue (kern_ap_continue),
      .last_latency     (last_latency),
      .job_count        (job_count)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic tick();
      @(negedge ap_clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check that every output sits at its reset value.
   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_done"},  32'(req_done),  32'd0);
      chk({tag, "_err"},   32'(req_err),   32'd0);
      chk({tag, "_sel"},   32'(sel),       32'd0);
      chk({tag, "_busy"},  32'(busy),      32'd0);
      chk({tag, "_start"}, 32'(kern_ap_start),    32'd0);
      chk({tag, "_cont"},  32'(kern_ap_continue), 32'd0);
      chk({tag, "_lat"},   last_latency, 32'd0);
      chk({tag, "_jobs"},  job_count,    32'd0);
   endtask

   // One successful job, called at a negedge with the scheduler in IDLE and the request set.
   // The kernel raises ap_ready in cycle kr and ap_done in cycle kd (cycle 1 = first START cycle).
   task automatic run_job(input int idx, input int kr, input int kd, input logic [3:0] valid_after);
      tick();
      chk($sformatf("grant%0d_ready", idx), 32'(req_ready), 32'd1 << idx);
      chk($sformatf("grant%0d_sel", idx),   32'(sel),       32'(idx));
      chk($sformatf("grant%0d_busy", idx),  32'(busy),      32'd1);
      req_valid = valid_after;
      for (int k = 1; k <= kd; k++) begin
         if (k > 1) tick();
         kern_ap_idle  = 1'b0;
         kern_ap_ready = (k == kr);
         kern_ap_done  = (k == kd);
         chk($sformatf("job%0d_start_c%0d", idx, k), 32'(kern_ap_start), 32'(k <= kr));
         if (k == 2) chk($sformatf("job%0d_ready_pulse", idx), 32'(req_ready), 32'd0);
      end
      tick();
      kern_ap_ready = 1'b0;
      kern_ap_done  = 1'b0;
      kern_ap_idle  = 1'b1;
      exp_jobs++;
      exp_last = kd;
      chk($sformatf("job%0d_done", idx), 32'(req_done),         32'd1 << idx);
      chk($sformatf("job%0d_cont", idx), 32'(kern_ap_continue), 32'd1);
      chk($sformatf("job%0d_err", idx),  32'(req_err),          32'd0);
      tick();
      chk($sformatf("job%0d_done_clr", idx), 32'(req_done), 32'd0);
      chk($sformatf("job%0d_idle_busy", idx), 32'(busy), 32'd0);
      chk($sformatf("job%0d_cont_clr", idx), 32'(kern_ap_continue), 32'd0);
      chk($sformatf("job%0d_last_lat", idx), last_latency, 32'(exp_last));
      chk($sformatf("job%0d_count", idx), job_count, 32'(exp_jobs));
   endtask

   initial begin
      ap_rst_n      = 1'b0;
      req_valid     = 4'b0000;
      kern_ap_ready = 1'b0;
      kern_ap_done  = 1'b0;
      kern_ap_idle  = 1'b1;
      tick();
      tick();
      chk_all_zero("reset");
      ap_rst_n = 1'b1;

      // All four requesting: strict rotation starting at index 0.
      req_valid = 4'b1111;
      run_job(0, 1, 3, 4'b1111);
      run_job(1, 2, 2, 4'b1111);
      run_job(2, 1, 1, 4'b1111);
      run_job(3, 3, 5, 4'b1111);
      run_job(0, 1, 2, 4'b1111);
      run_job(1, 1, 4, 4'b1111);
      run_job(2, 2, 3, 4'b1111);
      run_job(3, 1, 2, 4'b0000);

      // Single requester 2, ready in cycle 1, done 20 cycles later: latency 21.
      req_valid = 4'b0100;
      run_job(2, 1, 21, 4'b0000);

      // Pointer is 3; only requester 2 asks, so the pick wraps. ready+done together: latency 1.
      req_valid = 4'b0100;
      run_job(2, 1, 1, 4'b0000);

      // ap_ready held low for 5 cycles: start high for 6 cycles, drops on the 7th.
      req_valid = 4'b0001;
      run_job(0, 6, 8, 4'b0000);

      // Kernel not idle: no grant; stray ap_done while idle is ignored.
      req_valid    = 4'b0110;
      kern_ap_idle = 1'b0;
      kern_ap_done = 1'b1;
      tick();
      chk("idle_gate_ready1", 32'(req_ready), 32'd0);
      chk("idle_gate_busy1",  32'(busy),      32'd0);
      kern_ap_done = 1'b0;
      tick();
      chk("idle_gate_ready2", 32'(req_ready), 32'd0);
      chk("idle_gate_done2",  32'(req_done),  32'd0);
      kern_ap_idle = 1'b1;

      // Watchdog: pointer is 1, requester 1 granted, kernel never finishes.
      tick();
      chk("to_grant", 32'(req_ready), 32'b0010);
      chk("to_sel",   32'(sel),       32'd1);
      for (int k = 1; k <= 64; k++) begin
         if (k > 1) tick();
         kern_ap_idle  = 1'b0;
         kern_ap_ready = (k == 1);
         kern_ap_done  = 1'b0;
      end
      chk("to_err_before", 32'(req_err), 32'd0);
      chk("to_busy_before", 32'(busy), 32'd1);
      tick();
      chk("to_err_pulse",  32'(req_err),          32'b0010);
      chk("to_drain_cont", 32'(kern_ap_continue), 32'd1);
      chk("to_drain_start", 32'(kern_ap_start),   32'd0);
      chk("to_drain_done", 32'(req_done),         32'd0);
      kern_ap_done = 1'b1;
      tick();
      chk("to_err_once", 32'(req_err), 32'd0);
      chk("to_drain_wait_busy", 32'(busy), 32'd1);
      kern_ap_done = 1'b0;
      tick();
      chk("to_stray_done", 32'(req_done), 32'd0);
      chk("to_drain_wait_cont", 32'(kern_ap_continue), 32'd1);
      kern_ap_idle = 1'b1;
      tick();
      chk("to_idle_busy", 32'(busy), 32'd0);
      chk("to_jobs_kept", job_count, 32'(exp_jobs));
      chk("to_lat_kept",  last_latency, 32'(exp_last));
      // Requester 1 still asking, but the pointer moved past it.
      run_job(2, 2, 4, 4'b0000);

      // Reset in the middle of a RUN for requester 3, requester 0 arrives meanwhile.
      req_valid = 4'b1000;
      tick();
      chk("rst_grant", 32'(req_ready), 32'b1000);
      req_valid     = 4'b1001;
      kern_ap_idle  = 1'b0;
      kern_ap_ready = 1'b1;
      tick();
      kern_ap_ready = 1'b0;
      tick();
      chk("rst_run_busy", 32'(busy), 32'd1);
      #2;
      ap_rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      tick();
      chk("midrst_no_done", 32'(req_done), 32'd0);
      chk("midrst_no_err",  32'(req_err),  32'd0);
      ap_rst_n     = 1'b1;
      kern_ap_idle = 1'b1;
      exp_jobs     = 0;
      run_job(0, 1, 2, 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
